scariv_pht_update_queue: RTL and testbench

//  Consumes in-order resolved-branch updates from the fetch target queue (br_upd_fe_if side) and turns them into
//  2-bit saturating-counter writes to the gshare PHT write port. Buffers updates while the PHT port is busy,

---
 rtl/scariv_pht_update_queue_pkg.sv | 21 ++
 rtl/scariv_pht_update_queue_hit.sv | 24 ++
 rtl/scariv_pht_update_queue.sv | 178 +++++++++++++++++
 tb/tb_scariv_pht_update_queue.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/scariv_pht_update_queue_pkg.sv
// Shared types and helpers for the gshare PHT update queue.
// Holds the entry layout and the 2-bit saturating counter rule.
package scariv_pht_update_queue_pkg;

    localparam int unsigned PHT_IDX_W = 10;
    localparam int unsigned BHR_W     = 10;

    typedef struct packed {
        logic                 valid;
        logic [PHT_IDX_W-1:0] index;
        logic [1:0]           value;
    } pht_upd_entry_t;

    function automatic logic [1:0] pht_counter_next(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == 2'd3) ? 2'd3 : c + 2'd1;
        end
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

endpackage

// File: rtl/scariv_pht_update_queue_hit.sv
// Index CAM over the pending PHT update entries.
// Returns a one-hot hit vector and the value of the (unique) matching entry.
module scariv_pht_upd_hit
    import scariv_pht_update_queue_pkg::*;
#(
    parameter int unsigned Q_SIZE = 4
) (
    input  pht_upd_entry_t       i_entries [Q_SIZE],
    input  logic [PHT_IDX_W-1:0] i_index,
    output logic [Q_SIZE-1:0]    o_hit_oh,
    output logic [1:0]           o_hit_value
);

    always_comb begin
        o_hit_oh    = '0;
        o_hit_value = '0;
        for (int unsigned i = 0; i < Q_SIZE; i++) begin
            o_hit_oh[i] = i_entries[i].valid & (i_entries[i].index == i_index);
            // indexes are unique, so OR-ing is a plain select
            o_hit_value = o_hit_value | (i_entries[i].value & {2{o_hit_oh[i]}});
        end
    end

endmodule

// File: rtl/scariv_pht_update_queue.sv
// Turns retired conditional-branch updates into gshare PHT counter writes and keeps the committed BHR.
// Optional perf counters: define SCARIV_PHT_UPD_STAT_EN.
module scariv_pht_update_queue
  import scariv_pht_update_queue_pkg::*;
#(
  parameter int unsigned Q_SIZE = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_upd_valid,
  input  logic                 i_upd_is_cond,
  input  logic                 i_upd_dead,
  input  logic                 i_upd_taken,
  input  logic                 i_upd_mispredict,
  input  logic [PHT_IDX_W-1:0] i_upd_gshare_index,
  input  logic [BHR_W-1:0]     i_upd_gshare_bhr,
  input  logic [1:0]           i_upd_bim_value,
  output logic                 o_pht_wr_valid,
  input  logic                 i_pht_wr_ready,
  output logic [PHT_IDX_W-1:0] o_pht_wr_index,
  output logic [1:0]           o_pht_wr_value,
  output logic                 o_bhr_recover_valid,
  output logic [BHR_W-1:0]     o_bhr_recover,
  output logic [BHR_W-1:0]     o_committed_bhr,
  output logic                 o_upd_drop,
  output logic                 o_is_empty
);

  localparam int unsigned QW = (Q_SIZE > 1) ? $clog2(Q_SIZE) : 1;

  pht_upd_entry_t    entries_q [Q_SIZE];
  pht_upd_entry_t    entries_d [Q_SIZE];
  logic [QW-1:0]     head_q, head_d;
  logic [QW-1:0]     tail_q, tail_d;
  logic [BHR_W-1:0]  committed_bhr_q, committed_bhr_d;
  logic [BHR_W-1:0]  recover_q, recover_d;
  logic              recover_valid_q, recover_valid_d;
  logic              drop_q, drop_d;

  logic              train;
  logic              pop;
  logic              push;
  logic              merge;
  logic              full;
  logic [Q_SIZE-1:0] valid_vec;
  logic [Q_SIZE-1:0] pop_oh;
  logic [Q_SIZE-1:0] hit_oh;
  logic [Q_SIZE-1:0] merge_oh;
  logic [QW-1:0]     merge_idx;
  logic [1:0]        hit_value;
  logic [1:0]        base_value;
  logic [1:0]        new_value;
  logic              unused_bhr_msb;

  assign unused_bhr_msb = i_upd_gshare_bhr[BHR_W-1];

  scariv_pht_upd_hit #(
    .Q_SIZE (Q_SIZE)
  ) u_hit (
    .i_entries   (entries_q),
    .i_index     (i_upd_gshare_index),
    .o_hit_oh    (hit_oh),
    .o_hit_value (hit_value)
  );

  always_comb begin
    train = i_upd_valid & i_upd_is_cond & ~i_upd_dead;

    valid_vec = '0;
    for (int unsigned i = 0; i < Q_SIZE; i++) begin
      valid_vec[i] = entries_q[i].valid;
    end
    full = &valid_vec;

    o_pht_wr_valid = entries_q[head_q].valid;
    o_pht_wr_index = entries_q[head_q].index;
    o_pht_wr_value = entries_q[head_q].value;
    pop    = o_pht_wr_valid & i_pht_wr_ready;
    pop_oh = pop ? (Q_SIZE'(1) << head_q) : '0;

    // A hit on the draining head still supplies the base value, but the
    // result must be re-pushed because that entry leaves this cycle.
    merge_oh   = hit_oh & ~pop_oh;
    merge      = train & (|merge_oh);
    base_value = (|hit_oh) ? hit_value : i_upd_bim_value;
    new_value  = pht_counter_next(base_value, i_upd_taken);
    push       = train & ~merge & (~full | pop);
    drop_d     = train & ~merge & full & ~pop;

    merge_idx = '0;
    for (int unsigned i = 0; i < Q_SIZE; i++) begin
      if (merge_oh[i]) merge_idx = QW'(i);
    end

    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + QW'(1);
    end
    if (merge) begin
      entries_d[merge_idx].value = new_value;
    end
    if (push) begin
      entries_d[tail_q] = '{valid: 1'b1, index: i_upd_gshare_index, value: new_value};
      tail_d = tail_q + QW'(1);
    end

    committed_bhr_d = committed_bhr_q;
    recover_valid_d = 1'b0;
    recover_d       = recover_q;
    if (train) begin
      if (i_upd_mispredict) begin
        recover_valid_d = 1'b1;
        recover_d       = {i_upd_gshare_bhr[BHR_W-2:0], i_upd_taken};
        committed_bhr_d = {i_upd_gshare_bhr[BHR_W-2:0], i_upd_taken};
      end else begin
        committed_bhr_d = {committed_bhr_q[BHR_W-2:0], i_upd_taken};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < Q_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      committed_bhr_q <= '0;
      recover_q       <= '0;
      recover_valid_q <= 1'b0;
      drop_q          <= 1'b0;
    end else begin
      entries_q       <= entries_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      committed_bhr_q <= committed_bhr_d;
      recover_q       <= recover_d;
      recover_valid_q <= recover_valid_d;
      drop_q          <= drop_d;
    end
  end

  assign o_bhr_recover_valid = recover_valid_q;
  assign o_bhr_recover       = recover_q;
  assign o_committed_bhr     = committed_bhr_q;
  assign o_upd_drop          = drop_q;
  assign o_is_empty          = ~|valid_vec;

`ifdef SCARIV_PHT_UPD_STAT_EN
  logic [31:0] r_stat_push;
  logic [31:0] r_stat_merge;
  logic [31:0] r_stat_drop;
  logic [31:0] r_stat_wr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stat_push  <= '0;
      r_stat_merge <= '0;
      r_stat_drop  <= '0;
      r_stat_wr    <= '0;
    end else begin
      if (push   && r_stat_push  != '1) r_stat_push  <= r_stat_push  + 32'd1;
      if (merge  && r_stat_merge != '1) r_stat_merge <= r_stat_merge + 32'd1;
      if (drop_d && r_stat_drop  != '1) r_stat_drop  <= r_stat_drop  + 32'd1;
      if (pop    && r_stat_wr    != '1) r_stat_wr    <= r_stat_wr    + 32'd1;
    end
  end

  function void dump_pht_upd_perf(int fp);
    $display("  \"pht_update\" : { \"push\" : %0d, \"merge\" : %0d, \"drop\" : %0d, \"wr\" : %0d },",
             r_stat_push, r_stat_merge, r_stat_drop, r_stat_wr);
  endfunction
`endif

endmodule

// File: tb/tb_scariv_pht_update_queue.sv
// Directed table-driven bench for scariv_pht_update_queue, plus an async-reset sequence.
module tb_scariv_pht_update_queue;
    import scariv_pht_update_queue_pkg::*;

    logic                 clk;
    logic                 reset_n;
    logic                 upd_valid, upd_is_cond, upd_dead, upd_taken, upd_mispredict;
    logic [PHT_IDX_W-1:0] upd_index;
    logic [BHR_W-1:0]     upd_bhr;
    logic [1:0]           upd_bim;
    logic                 wr_valid, wr_ready;
    logic [PHT_IDX_W-1:0] wr_index;
    logic [1:0]           wr_value;
    logic                 rec_valid;
    logic [BHR_W-1:0]     rec_bhr;
    logic [BHR_W-1:0]     cbhr;
    logic                 drop;
    logic                 empty;

    int tests_run = 0;
    int tests_failed = 0;

    scariv_pht_update_queue #(
        .Q_SIZE (4)
    ) dut (
        .i_clk               (clk),
        .i_reset_n           (reset_n),
        .i_upd_valid         (upd_valid),
        .i_upd_is_cond       (upd_is_cond),
        .i_upd_dead          (upd_dead),
        .i_upd_taken         (upd_taken),
        .i_upd_mispredict    (upd_mispredict),
        .i_upd_gshare_index  (upd_index),
        .i_upd_gshare_bhr    (upd_bhr),
        .i_upd_bim_value     (upd_bim),
        .o_pht_wr_valid      (wr_valid),
        .i_pht_wr_ready      (wr_ready),
        .o_pht_wr_index      (wr_index),
        .o_pht_wr_value      (wr_value),
        .o_bhr_recover_valid (rec_valid),
        .o_bhr_recover       (rec_bhr),
        .o_committed_bhr     (cbhr),
        .o_upd_drop          (drop),
        .o_is_empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, is_cond, dead, taken, mis;
        logic [9:0]  idx;
        logic [9:0]  bhr;
        logic [1:0]  bim;
        logic        ready;
        logic        e_wv;
        logic [9:0]  e_wi;
        logic [1:0]  e_wval;
        logic        e_drop, e_empty;
        logic [9:0]  e_cbhr;
        logic        e_rv;
        logic [9:0]  e_rec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic c, logic d, logic t, logic m, logic [9:0] i,
                                logic [9:0] b, logic [1:0] bim, logic r, logic ewv, logic [9:0] ewi,
                                logic [1:0] ewval, logic edrop, logic eempty, logic [9:0] ecbhr,
                                logic erv, logic [9:0] erec);
        vec_t x;
        x.valid = v; x.is_cond = c; x.dead = d; x.taken = t; x.mis = m;
        x.idx = i; x.bhr = b; x.bim = bim; x.ready = r;
        x.e_wv = ewv; x.e_wi = ewi; x.e_wval = ewval; x.e_drop = edrop; x.e_empty = eempty;
        x.e_cbhr = ecbhr; x.e_rv = erv; x.e_rec = erec;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(vec_t x);
        upd_valid = x.valid; upd_is_cond = x.is_cond; upd_dead = x.dead;
        upd_taken = x.taken; upd_mispredict = x.mis; upd_index = x.idx;
        upd_bhr = x.bhr; upd_bim = x.bim; wr_ready = x.ready;
    endtask

    task automatic idle(logic ready);
        upd_valid = 0; upd_is_cond = 0; upd_dead = 0; upd_taken = 0; upd_mispredict = 0;
        upd_index = '0; upd_bhr = '0; upd_bim = '0; wr_ready = ready;
    endtask

    initial begin
        // inputs: valid,cond,dead,taken,mis,idx,bhr,bim,ready | expected after the edge:
        // wr_valid,wr_idx,wr_val,drop,empty,committed_bhr,rec_valid,rec
        vecs.push_back(mk(1,1,0,1,0, 5,0,1,1,   1, 5,2,0,0,10'h001,0,0));   // single update drains
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,   0, 0,0,0,1,10'h001,0,0));
        vecs.push_back(mk(1,1,0,1,0, 5,0,1,0,   1, 5,2,0,0,10'h003,0,0));   // merge chain 2,3,3
        vecs.push_back(mk(1,1,0,1,0, 5,0,1,0,   1, 5,3,0,0,10'h007,0,0));
        vecs.push_back(mk(1,1,0,1,0, 5,0,1,0,   1, 5,3,0,0,10'h00F,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,   0, 0,0,0,1,10'h00F,0,0));
        vecs.push_back(mk(1,1,0,0,0, 1,0,0,0,   1, 1,0,0,0,10'h01E,0,0));   // fill 4 entries, floor at 0
        vecs.push_back(mk(1,1,0,1,0, 2,0,2,0,   1, 1,0,0,0,10'h03D,0,0));
        vecs.push_back(mk(1,1,0,0,0, 3,0,3,0,   1, 1,0,0,0,10'h07A,0,0));
        vecs.push_back(mk(1,1,0,0,0, 4,0,1,0,   1, 1,0,0,0,10'h0F4,0,0));
        vecs.push_back(mk(1,1,0,1,0, 6,0,1,0,   1, 1,0,1,0,10'h1E9,0,0));   // full -> drop, BHR still shifts
        vecs.push_back(mk(1,1,0,1,0, 7,0,2,1,   1, 2,3,0,0,10'h3D3,0,0));   // full + pop -> accepted
        vecs.push_back(mk(1,0,0,1,0, 8,0,1,1,   1, 3,2,0,0,10'h3D3,0,0));   // non-cond ignored
        vecs.push_back(mk(1,1,1,1,1, 9,10'h155,1,1, 1,4,0,0,0,10'h3D3,0,0)); // dead ignored
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,   1, 7,3,0,0,10'h3D3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,   0, 0,0,0,1,10'h3D3,0,0));
        vecs.push_back(mk(1,1,0,1,1, 9,10'h155,1,1, 1,9,2,0,0,10'h2AB,1,10'h2AB)); // mispredict recover
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,   0, 0,0,0,1,10'h2AB,0,0));
        vecs.push_back(mk(1,1,0,1,0,10,0,0,0,   1,10,1,0,0,10'h157,0,0));
        vecs.push_back(mk(1,1,0,1,0,10,0,0,1,   1,10,2,0,0,10'h2AF,0,0));   // hit on popped head -> re-push
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,   0, 0,0,0,1,10'h2AF,0,0));

        reset_n = 1'b0;
        idle(1'b0);
        #1;
        chk("reset wr_valid", 32'(wr_valid), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset cbhr", 32'(cbhr), 0);
        chk("reset drop", 32'(drop), 0);
        chk("reset rec_valid", 32'(rec_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d wr_valid", k), 32'(wr_valid), 32'(vecs[k].e_wv));
            if (vecs[k].e_wv) begin
                chk($sformatf("row%0d wr_index", k), 32'(wr_index), 32'(vecs[k].e_wi));
                chk($sformatf("row%0d wr_value", k), 32'(wr_value), 32'(vecs[k].e_wval));
            end
            chk($sformatf("row%0d drop", k), 32'(drop), 32'(vecs[k].e_drop));
            chk($sformatf("row%0d empty", k), 32'(empty), 32'(vecs[k].e_empty));
            chk($sformatf("row%0d cbhr", k), 32'(cbhr), 32'(vecs[k].e_cbhr));
            chk($sformatf("row%0d rec_valid", k), 32'(rec_valid), 32'(vecs[k].e_rv));
            if (vecs[k].e_rv) begin
                chk($sformatf("row%0d rec", k), 32'(rec_bhr), 32'(vecs[k].e_rec));
            end
        end

        // Three pending entries, then async reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            upd_valid = 1; upd_is_cond = 1; upd_taken = 1; upd_index = 10'(11 + k); upd_bim = 2'd1;
            @(posedge clk);
            #1;
        end
        idle(1'b0);
        chk("pre-reset empty", 32'(empty), 0);
        chk("pre-reset wr_index", 32'(wr_index), 11);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset wr_valid", 32'(wr_valid), 0);
        chk("async reset empty", 32'(empty), 1);
        chk("async reset cbhr", 32'(cbhr), 0);
        chk("async reset rec_valid", 32'(rec_valid), 0);
        chk("async reset drop", 32'(drop), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset empty", 32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
